// File: rtl/pwm_capture_pkg.sv
// Shared state encoding and default sizing for the PWM capture block.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCKST = 2'd2
  } cap_state_t;

  localparam int DEF_DW      = 4;
  localparam int DEF_CW      = 8;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM line into the clock domain and flags its rising edges.
module pwm_in_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm_in,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform between rising edges,
// and reports a stuck line once no rising edge has arrived for TIMEOUT cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pwm_in,
  output logic [DW-1:0] o_duty,
  output logic [CW-1:0] o_period_cnt,
  output logic          o_valid,
  output logic          o_locked,
  output logic          o_stuck
);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_CW = CW'(TIMEOUT);
  localparam logic [CW-1:0] DUTY_MAX   = CW'((1 << DW) - 1);

  logic          w_s2;
  logic          w_rise;
  logic [CW-1:0] w_per_next;
  logic [CW-1:0] w_hi_next;
  logic [DW-1:0] w_duty_sat;
  logic          w_timeout;

  cap_state_t    r_state;
  logic [CW-1:0] r_per_cnt;
  logic [CW-1:0] r_hi_cnt;
  logic [DW-1:0] r_duty;
  logic [CW-1:0] r_period_cnt;
  logic          r_valid;
  logic          r_locked;
  logic          r_stuck;

  pwm_in_sync u_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_pwm_in (i_pwm_in),
    .o_level  (w_s2),
    .o_rise   (w_rise)
  );

  // Both counters saturate so a very long period cannot wrap into a short-looking one.
  assign w_per_next = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_ONE;
  assign w_hi_next  = (w_s2 && (r_hi_cnt != CNT_MAX)) ? r_hi_cnt + CNT_ONE : r_hi_cnt;
  assign w_duty_sat = (r_hi_cnt > DUTY_MAX) ? '1 : r_hi_cnt[DW-1:0];
  assign w_timeout  = (r_per_cnt == TIMEOUT_CW);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_duty       <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_per_cnt <= w_per_next;
      r_hi_cnt  <= w_hi_next;
      case (r_state)
        IDLE, MEASURE: begin
          // A rise on the timeout cycle still counts as a normal edge.
          if (w_rise) begin
            r_state   <= MEASURE;
            r_per_cnt <= CNT_ONE;
            r_hi_cnt  <= CNT_ONE;
            if (r_state == MEASURE) begin
              r_duty       <= w_duty_sat;
              r_period_cnt <= r_per_cnt;
              r_valid      <= 1'b1;
              r_locked     <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state      <= STUCKST;
            r_valid      <= 1'b1;
            r_stuck      <= 1'b1;
            r_locked     <= 1'b0;
            r_period_cnt <= '0;
            r_duty       <= w_s2 ? '1 : '0;
          end
        end
        STUCKST: begin
          r_per_cnt <= r_per_cnt;
          r_hi_cnt  <= r_hi_cnt;
          // The first period after recovery has no framing edge, so it is not reported.
          if (w_rise) begin
            r_state   <= MEASURE;
            r_stuck   <= 1'b0;
            r_per_cnt <= CNT_ONE;
            r_hi_cnt  <= CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_duty       = r_duty;
  assign o_period_cnt = r_period_cnt;
  assign o_valid      = r_valid;
  assign o_locked     = r_locked;
  assign o_stuck      = r_stuck;

endmodule
